// File: rtl/pong_pkg.sv
// Shared state encoding and default sizing for the pong frame sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        ENG        = 3'd2,
        AI         = 3'd3,
        COMMIT     = 3'd4
    } state_t;

    localparam int DEF_TIMEOUT_W = 16;
    localparam int DEF_TIMEOUT   = 40000;
    localparam int DEF_COUNT_W   = 16;

endpackage

// File: rtl/frame_sequencer_sync_edge.sv
// Two-flop synchronizer with a registered previous value, giving level plus
// single-cycle rise/fall pulses in the destination clock domain.
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: on each vsync fall runs one engine step, one AI step,
// then a commit strobe. Optional single-step gating via FRAME_SEQ_SINGLE_STEP_EN.
module frame_sequencer
    import pong_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int COUNT_W   = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               run,
    output logic               eng_req,
    input  logic               eng_ack,
    output logic               ai_req,
    input  logic               ai_ack,
    output logic               commit,
    output logic               busy,
    output logic [COUNT_W-1:0] frame_count,
    output logic               overrun,
    output logic               timeout_err
`ifdef FRAME_SEQ_SINGLE_STEP_EN
    ,
    input  logic               step_mode,
    input  logic               step_btn
`endif
);

    // Step is abandoned on the edge where the watchdog would reach TIMEOUT-1.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 2);

    state_t               r_state;
    state_t               w_next;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [COUNT_W-1:0]   r_frame_count;
    logic                 r_overrun;
    logic                 r_timeout_err;
    logic                 w_tick;
    logic                 w_vs_level;
    logic                 w_vs_rise;
    logic                 w_wd_expired;
    logic                 w_step_ok;
    logic                 w_busy;
    logic                 w_step_tmo;
    logic                 w_unused_sync;

    sync_edge #(.RST_VAL(1'b1)) u_vsync_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_async (vsync),
        .o_level (w_vs_level),
        .o_rise  (w_vs_rise),
        .o_fall  (w_tick)
    );

`ifdef FRAME_SEQ_SINGLE_STEP_EN
    logic r_step_pending;
    logic w_btn_level;
    logic w_btn_rise;
    logic w_btn_fall;

    sync_edge #(.RST_VAL(1'b0)) u_btn_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_async (step_btn),
        .o_level (w_btn_level),
        .o_rise  (w_btn_rise),
        .o_fall  (w_btn_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_pending <= 1'b0;
        end else if (!step_mode) begin
            r_step_pending <= 1'b0;
        end else if (r_state == WAIT_FRAME && w_next == ENG) begin
            r_step_pending <= 1'b0;
        end else if (w_btn_rise) begin
            r_step_pending <= 1'b1;
        end
    end

    assign w_step_ok     = ~step_mode | r_step_pending;
    assign w_unused_sync = ^{w_vs_level, w_vs_rise, w_btn_level, w_btn_fall};
`else
    assign w_step_ok     = 1'b1;
    assign w_unused_sync = ^{w_vs_level, w_vs_rise};
`endif

    assign w_wd_expired = (r_wd == WD_LAST);
    assign w_busy       = (r_state == ENG) || (r_state == AI) || (r_state == COMMIT);
    assign w_step_tmo   = ((r_state == ENG) && !eng_ack && w_wd_expired) ||
                          ((r_state == AI)  && !ai_ack  && w_wd_expired);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (run) w_next = WAIT_FRAME;
            WAIT_FRAME: begin
                if (w_tick && w_step_ok) w_next = ENG;
                else if (!run)           w_next = IDLE;
            end
            ENG: begin
                if (eng_ack)           w_next = AI;
                else if (w_wd_expired) w_next = WAIT_FRAME;
            end
            AI: begin
                if (ai_ack)            w_next = COMMIT;
                else if (w_wd_expired) w_next = WAIT_FRAME;
            end
            COMMIT:     w_next = run ? WAIT_FRAME : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_wd          <= '0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            // Watchdog restarts from zero whenever a step state is entered.
            if ((r_state == ENG || r_state == AI) && w_next == r_state)
                r_wd <= r_wd + TIMEOUT_W'(1);
            else
                r_wd <= '0;
            if (r_state == COMMIT)
                r_frame_count <= r_frame_count + COUNT_W'(1);
            if (r_state == IDLE && run) begin
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end else begin
                if (w_tick && w_busy) r_overrun     <= 1'b1;
                if (w_step_tmo)       r_timeout_err <= 1'b1;
            end
        end
    end

    assign eng_req     = (r_state == ENG);
    assign ai_req      = (r_state == AI);
    assign commit      = (r_state == COMMIT);
    assign busy        = w_busy;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized scoreboard bench for frame_sequencer: stimulus predicts commits
// from frame-level rules; a monitor pops expectations on each commit pulse.
module tb_frame_sequencer;

    localparam int TMO     = 64;
    localparam int CW      = 4;
    localparam int CNT_MOD = 1 << CW;

    logic          clk;
    logic          reset;
    logic          vsync;
    logic          run;
    logic          eng_req;
    logic          eng_ack;
    logic          ai_req;
    logic          ai_ack;
    logic          commit;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic          overrun;
    logic          timeout_err;
`ifdef FRAME_SEQ_SINGLE_STEP_EN
    logic          step_mode;
    logic          step_btn;
`endif

    frame_sequencer #(.TIMEOUT_W(16), .TIMEOUT(TMO), .COUNT_W(CW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .run         (run),
        .eng_req     (eng_req),
        .eng_ack     (eng_ack),
        .ai_req      (ai_req),
        .ai_ack      (ai_ack),
        .commit      (commit),
        .busy        (busy),
        .frame_count (frame_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
`ifdef FRAME_SEQ_SINGLE_STEP_EN
        ,
        .step_mode   (step_mode),
        .step_btn    (step_btn)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sb_q[$];
    int exp_count = 0;
    bit exp_ovr = 0;
    bit exp_tmo = 0;
    bit running = 0;
    bit post_pend = 0;
    int post_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every commit pulse must match the oldest predicted commit.
    always @(negedge clk) begin
        if (reset) begin
            if (post_pend) begin
                check("count_after_commit", int'(frame_count), post_exp);
                post_pend = 0;
            end
            if (commit) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    check("count_at_commit", int'(frame_count), e);
                    post_pend = 1;
                    post_exp  = (e + 1) % CNT_MOD;
                end
            end
        end
    end

    task automatic ensure_running();
        if (!running) begin
            @(negedge clk);
            run = 1'b1;
            @(posedge clk);
            exp_ovr = 0;
            exp_tmo = 0;
            running = 1;
            @(negedge clk);
            check("ovr_cleared", int'(overrun), 0);
            check("tmo_cleared", int'(timeout_err), 0);
        end
    endtask

    // Drive one step; returns early if reset is pulsed inside the AI step.
    task automatic step(input bit which, input int dd, input int ov,
                        input bit drop, input int rst_at);
        int i = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clk);
            if (!which) begin
                check("eng_req_hold", int'(eng_req), 1);
                check("ai_req_in_eng", int'(ai_req), 0);
                eng_ack = (i == dd);
                ai_ack  = 1'($urandom_range(0, 1));
                vsync   = !(ov >= 0 && i >= ov && i < ov + 3);
                if (drop && i == 0) run = 1'b0;
            end else begin
                check("ai_req_hold", int'(ai_req), 1);
                check("eng_req_in_ai", int'(eng_req), 0);
                ai_ack  = (i == dd);
                eng_ack = 1'($urandom_range(0, 1));
                vsync   = 1'b1;
                if (i == rst_at) begin
                    #2 reset = 1'b0;
                    #1;
                    check("rst_eng_req", int'(eng_req), 0);
                    check("rst_ai_req", int'(ai_req), 0);
                    check("rst_commit", int'(commit), 0);
                    check("rst_busy", int'(busy), 0);
                    check("rst_count", int'(frame_count), 0);
                    check("rst_ovr", int'(overrun), 0);
                    check("rst_tmo", int'(timeout_err), 0);
                    done = 1;
                end
            end
            if (!done) begin
                @(posedge clk);
                if (i == dd || i == TMO - 2) done = 1;
                i++;
            end
        end
    endtask

    task automatic frame(input int d, input int d2, input int ov_in, input bit drop_run,
                         input bit drop_tick, input int rst_at);
        bit ok1, ok2;
        int ov, lim;
        ov  = ov_in;
        lim = (d < TMO - 2) ? d : TMO - 2;
        if (ov < 2 || ov + 2 > lim) ov = -1;
        ok1 = (d <= TMO - 2);
        ok2 = ok1 && (d2 <= TMO - 2);
        if (rst_at < 0) begin
            if (ok2) begin
                sb_q.push_back(exp_count);
                exp_count = (exp_count + 1) % CNT_MOD;
            end else begin
                exp_tmo = 1;
            end
        end
        if (ov >= 0) exp_ovr = 1;
        @(negedge clk);
        vsync   = 1'b0;
        eng_ack = 1'($urandom_range(0, 1));
        ai_ack  = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(posedge clk);
        #1 check("eng_req_early", int'(eng_req), 0);
        @(negedge clk);
        if (drop_tick) run = 1'b0;
        @(posedge clk);
        #1 check("eng_req_latency", int'(eng_req), 1);
        check("busy_in_eng", int'(busy), 1);
        step(1'b0, d, ov, drop_run, -1);
        if (ok1) step(1'b1, d2, -1, 1'b0, rst_at);
        if (rst_at >= 0) begin
            @(negedge clk);
            reset = 1'b1;
            eng_ack = 1'b0;
            ai_ack = 1'b0;
            exp_count = 0;
            exp_ovr = 0;
            exp_tmo = 0;
            running = 0;
            return;
        end
        @(negedge clk);
        eng_ack = 1'b0;
        ai_ack  = 1'b0;
        vsync   = 1'b1;
        if (ok2) begin
            check("commit_pulse", int'(commit), 1);
            check("busy_in_commit", int'(busy), 1);
            @(negedge clk);
        end
        check("commit_done", int'(commit), 0);
        check("busy_after", int'(busy), 0);
        check("eng_req_after", int'(eng_req), 0);
        check("ai_req_after", int'(ai_req), 0);
        check("overrun_flag", int'(overrun), int'(exp_ovr));
        check("timeout_flag", int'(timeout_err), int'(exp_tmo));
        if (!run) running = 0;
    endtask

    task automatic rand_delay(output int v);
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 70)      v = $urandom_range(0, 20);
        else if (sel < 85) v = $urandom_range(TMO - 3, TMO - 1);
        else               v = 200;
    endtask

    initial begin
        reset   = 1'b0;
        vsync   = 1'b1;
        run     = 1'b0;
        eng_ack = 1'b0;
        ai_ack  = 1'b0;
`ifdef FRAME_SEQ_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_btn  = 1'b0;
`endif
        #1;
        check("reset_eng_req", int'(eng_req), 0);
        check("reset_ai_req", int'(ai_req), 0);
        check("reset_commit", int'(commit), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(frame_count), 0);
        check("reset_ovr", int'(overrun), 0);
        check("reset_tmo", int'(timeout_err), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        ensure_running();
        frame(4, 2, -1, 0, 0, -1);
        frame(30, 3, 5, 0, 0, -1);
        frame(1, TMO - 2, -1, 0, 0, -1);
        frame(2, 200, -1, 0, 0, -1);
        frame(0, 0, -1, 0, 0, -1);
        frame(TMO - 1, 0, -1, 0, 0, -1);
        frame(5, 1, -1, 1, 0, -1);

        repeat (3) @(negedge clk);
        vsync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) vsync = 1'b1;
            check("idle_no_req", int'(eng_req), 0);
            check("idle_not_busy", int'(busy), 0);
        end
        check("idle_ovr_kept", int'(overrun), int'(exp_ovr));

        ensure_running();
        frame(3, 3, -1, 0, 1, -1);
        ensure_running();

        for (int f = 0; f < 40; f++) begin
            int d, d2, ov;
            bit dr;
            rand_delay(d);
            rand_delay(d2);
            ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : -1;
            dr = ($urandom_range(0, 9) == 0);
            ensure_running();
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                check("wait_not_busy", int'(busy), 0);
            end
            frame(d, d2, ov, dr, 1'b0, -1);
        end

        ensure_running();
        frame(3, 200, -1, 0, 0, 5);
        ensure_running();
        frame(2, 2, -1, 0, 0, -1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame update scheduler for the pong datapath. Runs in the system clock domain and detects the start of vertical sync.
- Sequences one game-engine step, then one AI step, using req/ack handshakes. Then issues a single commit strobe that latches the new positions.
- Replaces use of vsync as a clock. Sits between the graphics timing generator, game_sm, AI and the position registers in pong_top.

Parameters:
- TIMEOUT_W, 16, width of the per-step watchdog counter
- TIMEOUT, 16'd40000, clk cycles allowed for an ack before the step is abandoned
- COUNT_W, 16, width of frame_count

Ports:
- clk  input  1  system clock (DIV_CLK-derived pixel clock domain)
- reset  input  1  asynchronous, active-low reset
- vsync  input  1  vga_v_sync from graphics; active-low pulse; asynchronous to clk
- run  input  1  level enable (start_game switch)
- eng_req  output  1  request one game_sm step
- eng_ack  input  1  game_sm step done
- ai_req  output  1  request one AI step
- ai_ack  input  1  AI step done
- commit  output  1  one-cycle strobe that loads the *_q position registers
- busy  output  1  high in ENG, AI, COMMIT
- frame_count  output  COUNT_W  committed frames
- overrun  output  1  sticky: frame tick arrived while busy
- timeout_err  output  1  sticky: an ack did not arrive within TIMEOUT

Behaviour:
- Reset (reset=0, async): state IDLE; eng_req=ai_req=commit=busy=0; frame_count=0; overrun=timeout_err=0; synchronizer flops=1; watchdog=0.
- vsync path: 2-flop synchronizer, then a falling-edge detector on the synced value gives a 1-cycle frame_tick.
- Latency: eng_req rises on the 3rd clk edge, counting the first edge that samples vsync=0 (2 sync stages + 1 state register).
- IDLE:
  - run=1 moves to WAIT_FRAME on the next edge.
  - That transition also clears overrun and timeout_err.
  - frame_tick is ignored in IDLE.
- WAIT_FRAME:
  - frame_tick moves to ENG.
  - run=0 with no tick moves to IDLE.
  - tick and run=0 in the same cycle: the tick wins, and the sequence completes before IDLE.
- ENG:
  - eng_req=1 (Moore output).
  - eng_ack=1 sampled at an edge moves to AI; eng_req is low in the following cycle.
  - Minimum dwell is 1 cycle, so an ack can be high in the first ENG cycle.
- AI: same rules as ENG, using ai_req/ai_ack; ack moves to COMMIT.
- Acks are ignored in every state except their own. An ack that is held high across states is only sampled in its own state.
- COMMIT:
  - commit=1 for exactly one cycle.
  - frame_count increments modulo 2^COUNT_W, wrapping from 0xFFFF to 0.
  - Next state is WAIT_FRAME if run=1, else IDLE.
- Watchdog:
  - Cleared on entry to ENG and to AI; increments each cycle in that state without an ack.
  - Reaching TIMEOUT-1 without an ack sets timeout_err and moves to WAIT_FRAME.
  - On timeout there is no commit and frame_count is unchanged.
  - An ack on the timeout cycle wins: the step succeeds.
- frame_tick while in ENG, AI or COMMIT sets overrun. The tick is dropped, not queued.
- run=0 mid-sequence does not abort; the current frame finishes through COMMIT.
- busy = state is ENG, AI or COMMIT.

Optional Feature:
- Macro: FRAME_SEQ_SINGLE_STEP_EN
- Defined:
  - Adds ports step_mode (in, 1) and step_btn (in, 1, asynchronous; btnC).
  - step_btn goes through its own synchronizer; a rising edge sets a one-deep step_pending flag. Further presses while pending are no-ops.
  - With step_mode=1, frame_tick in WAIT_FRAME starts a sequence only if step_pending=1; the flag is cleared on entry to ENG.
  - With step_mode=0, behaviour is normal and step_pending is held clear.
  - Reset clears step_pending.
- Undefined: the ports and logic are absent, and every tick in WAIT_FRAME runs a frame.

Decomposition:
- Package pong_pkg holds:
  - state encoding, 3 bits: IDLE=0, WAIT_FRAME=1, ENG=2, AI=3, COMMIT=4; other codes recover to IDLE
  - default TIMEOUT and COUNT_W constants
- One sub-module, sync_edge:
  - 2-flop synchronizer plus registered previous value
  - outputs: synced level, rise pulse, fall pulse
  - reset value parameterised
  - instantiated for vsync (reset value 1) and, when the macro is enabled, for step_btn (reset value 0)

Test Plan:
- Normal frame: reset released, run=1, vsync falls; eng_ack 4 cycles after eng_req, ai_ack 2 cycles after ai_req -> eng_req on edge 3, ai_req after the eng_ack edge, one commit pulse, frame_count 0->1, busy low afterwards.
- Overrun: eng_ack withheld; second vsync fall after 1000 cycles; TIMEOUT=5000 -> overrun=1; eng_ack arrives later, sequence completes, exactly one commit.
- Timeout: TIMEOUT=16, ai_ack never asserted -> timeout_err=1 after 15 AI cycles, no commit, frame_count unchanged, back in WAIT_FRAME; next frame succeeds normally.
- Stop mid-frame: run=0 during ENG -> sequence finishes, commit pulses once, state IDLE; later vsync falls give no eng_req.
- Wrap and reset: preload by running 65536 frames (or force) -> frame_count wraps 0xFFFF->0; reset asserted during AI -> all outputs 0 immediately, without waiting for a clk edge.
- FRAME_SEQ_SINGLE_STEP_EN, step_mode=1: 3 vsync falls with no press give no eng_req; one step_btn press then 2 vsync falls give exactly one frame, frame_count +1.
